// File: rtl/demux1to4_deser.sv
// 1-to-4 demultiplexer/deserializer: steers a serial bit stream into four lanes
// and presents each completed word on a valid/ready output. Optional: DEMUX_OVERRUN_EN.
module demux1to4_deser #(
    parameter logic [3:0] RESET_WORD = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_in,
    input  logic       d_valid,
    output logic       d_ready,
    input  logic       auto_mode,
    input  logic [1:0] select,
    output logic [3:0] q,
    output logic       q_valid,
    input  logic       q_ready,
    output logic [1:0] lane_idx,
`ifdef DEMUX_OVERRUN_EN
    output logic       overrun,
`endif
    output logic [3:0] fill_mask
);

    typedef enum logic {COLLECT, HOLD} state_e;

    state_e     state_q;
    logic [3:0] q_q;
    logic [3:0] shadow_q, shadow_d;
    logic [3:0] fill_q, fill_d;
    logic [1:0] lane_q, lane_d;
    logic       mode_q;

    logic       mode_change;
    logic [3:0] base_fill;
    logic [1:0] base_lane;
    logic [1:0] lane_sel;
    logic [3:0] merged_fill;
    logic       accept;
    logic       complete;

    assign q_valid   = (state_q == HOLD);
    assign d_ready   = !q_valid || q_ready;
    assign q         = q_q;
    assign lane_idx  = lane_q;
    assign fill_mask = fill_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        mode_change = (auto_mode != mode_q);
        // A mode change discards the partial word before this cycle's bit is placed.
        base_fill   = mode_change ? 4'b0000 : fill_q;
        base_lane   = mode_change ? 2'd0    : lane_q;
        lane_sel    = auto_mode ? base_lane : select;
        accept      = d_valid && d_ready;
        merged_fill = base_fill | (4'b0001 << lane_sel);
        complete    = accept && (merged_fill == 4'b1111);

        shadow_d = shadow_q;
        fill_d   = base_fill;
        lane_d   = base_lane;
        if (accept) begin
            shadow_d[lane_sel] = d_in;
        end
        if (complete) begin
            fill_d = 4'b0000;
            lane_d = 2'd0;
        end else if (accept) begin
            fill_d = merged_fill;
            if (auto_mode) begin
                lane_d = base_lane + 2'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= COLLECT;
            q_q      <= RESET_WORD;
            shadow_q <= RESET_WORD;
            fill_q   <= 4'b0000;
            lane_q   <= 2'd0;
            mode_q   <= 1'b0;
        end else begin
            mode_q   <= auto_mode;
            shadow_q <= shadow_d;
            fill_q   <= fill_d;
            lane_q   <= lane_d;
            case (state_q)
                COLLECT: begin
                    if (complete) begin
                        q_q     <= shadow_d;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    // A completion on the consuming edge replaces the word and keeps q_valid high.
                    if (complete) begin
                        q_q <= shadow_d;
                    end else if (q_ready) begin
                        state_q <= COLLECT;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

`ifdef DEMUX_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (d_valid && !d_ready) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_demux1to4_deser.sv
// Directed self-checking bench for demux1to4_deser; covers overrun when DEMUX_OVERRUN_EN is defined.
module tb_demux1to4_deser;

    localparam logic [3:0] RST_WORD = 4'b0101;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_in;
    logic       d_valid;
    logic       d_ready;
    logic       auto_mode;
    logic [1:0] select;
    logic [3:0] q;
    logic       q_valid;
    logic       q_ready;
    logic [1:0] lane_idx;
    logic [3:0] fill_mask;
`ifdef DEMUX_OVERRUN_EN
    logic       overrun;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux1to4_deser #(.RESET_WORD(RST_WORD)) dut (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_in),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .auto_mode (auto_mode),
        .select    (select),
        .q         (q),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .lane_idx  (lane_idx),
`ifdef DEMUX_OVERRUN_EN
        .overrun   (overrun),
`endif
        .fill_mask (fill_mask)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] bits_a;
    logic [3:0] bits_b;
    logic [1:0] msel [5];
    logic       mbit [5];
    logic [3:0] mfill [4];

    initial begin
        rst = 1'b1; d_in = 1'b0; d_valid = 1'b0; auto_mode = 1'b0;
        select = 2'd0; q_ready = 1'b0;
        tick();
        tick();
        check("rst_q", q, RST_WORD);
        check("rst_q_valid", q_valid, 0);
        check("rst_lane", lane_idx, 0);
        check("rst_fill", fill_mask, 0);
        check("rst_d_ready", d_ready, 1);
`ifdef DEMUX_OVERRUN_EN
        check("rst_overrun", overrun, 0);
`endif

        // Auto word: bits 1,0,1,1 to lanes 0..3 -> 4'b1101
        rst = 1'b0; auto_mode = 1'b1; q_ready = 1'b1; d_valid = 1'b1;
        d_in = 1'b1; tick();
        check("auto_lane1", lane_idx, 1);
        check("auto_fill1", fill_mask, 4'b0001);
        check("auto_valid_early", q_valid, 0);
        d_in = 1'b0; tick();
        d_in = 1'b1; tick();
        check("auto_lane3", lane_idx, 3);
        d_in = 1'b1; tick();
        check("auto_q", q, 4'b1101);
        check("auto_q_valid", q_valid, 1);
        check("auto_lane_wrap", lane_idx, 0);
        check("auto_fill_clr", fill_mask, 0);
        d_valid = 1'b0; tick();
        check("auto_valid_1cyc", q_valid, 0);

        // Manual out-of-order writes with one overwrite
        msel  = '{2'd2, 2'd0, 2'd2, 2'd3, 2'd1};
        mbit  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        mfill = '{4'b0100, 4'b0101, 4'b0101, 4'b1101};
        auto_mode = 1'b0; d_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            select = msel[i]; d_in = mbit[i];
            tick();
            if (i < 4) begin
                check($sformatf("man_fill%0d", i), fill_mask, mfill[i]);
                check($sformatf("man_lane%0d", i), lane_idx, 0);
            end
        end
        check("man_q", q, 4'b1001);
        check("man_q_valid", q_valid, 1);
        check("man_fill_clr", fill_mask, 0);
        d_valid = 1'b0; tick();
        check("man_valid_clr", q_valid, 0);

        // Back-pressure: word A=1010 held, blocked bit dropped, then B=0110
        bits_a = 4'b1010;
        bits_b = 4'b0110;
        auto_mode = 1'b1; q_ready = 1'b0; d_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d_in = bits_a[i];
            tick();
        end
        check("bp_qa", q, 4'b1010);
        check("bp_qa_valid", q_valid, 1);
        d_in = 1'b1;
        #1;
        check("bp_d_ready_low", d_ready, 0);
        tick();
        check("bp_hold_q", q, 4'b1010);
        check("bp_hold_valid", q_valid, 1);
        check("bp_drop_fill", fill_mask, 0);
        check("bp_drop_lane", lane_idx, 0);
`ifdef DEMUX_OVERRUN_EN
        check("ovr_set", overrun, 1);
`endif
        q_ready = 1'b1;
        d_in = bits_b[0];
        #1;
        check("bp_d_ready_high", d_ready, 1);
        tick();
        check("bp_a_consumed", q_valid, 0);
        check("bp_b_fill1", fill_mask, 4'b0001);
        for (int i = 1; i < 4; i++) begin
            d_in = bits_b[i];
            tick();
        end
        check("bp_qb", q, 4'b0110);
        check("bp_qb_valid", q_valid, 1);
`ifdef DEMUX_OVERRUN_EN
        check("ovr_sticky", overrun, 1);
`endif
        d_valid = 1'b0; tick();
        check("bp_b_consumed", q_valid, 0);

        // Mode switch mid-word
        d_valid = 1'b1; d_in = 1'b1;
        tick();
        tick();
        check("sw_lane2", lane_idx, 2);
        check("sw_fill2", fill_mask, 4'b0011);
        auto_mode = 1'b0; select = 2'd3; d_in = 1'b1;
        tick();
        check("sw_fill", fill_mask, 4'b1000);
        check("sw_lane", lane_idx, 0);
        check("sw_q_valid", q_valid, 0);

        // Reset mid-word
        d_valid = 1'b0; rst = 1'b1;
        tick();
        check("rmid_fill", fill_mask, 0);
        check("rmid_lane", lane_idx, 0);
        check("rmid_q", q, RST_WORD);
`ifdef DEMUX_OVERRUN_EN
        check("ovr_rst", overrun, 0);
`endif

        // Reset with a pending word and blocked input
        rst = 1'b0; q_ready = 1'b0; d_valid = 1'b1; d_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            select = 2'(i);
            tick();
        end
        check("rv_q", q, 4'b1111);
        check("rv_q_valid", q_valid, 1);
        rst = 1'b1;
        tick();
        check("rv_rst_q", q, RST_WORD);
        check("rv_rst_q_valid", q_valid, 0);
        check("rv_rst_fill", fill_mask, 0);
        check("rv_rst_lane", lane_idx, 0);
        check("rv_rst_d_ready", d_ready, 1);
`ifdef DEMUX_OVERRUN_EN
        check("ovr_rst2", overrun, 0);
`endif
        rst = 1'b0; d_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
